// File: rtl/seq_stream_arbiter.sv
// seq_stream_arbiter: round-robin sharing of one serial Mealy core.
// Optional SEQ_ARB_PRIO0_EN: requester 0 wins over round-robin.
module seq_stream_arbiter #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8,
    parameter int IDW       = 2
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*FRAME_LEN-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      core_rst,
    output logic                      core_din,
    input  logic                      core_dout,
    output logic                      res_valid,
    output logic [IDW-1:0]            res_id,
    output logic [FRAME_LEN-1:0]      res_data,
    input  logic                      res_ready
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] sh_q, sh_d;
    logic [FRAME_LEN-1:0] res_q, res_d;
    logic                 found;
    logic [IDW-1:0]       win;

    // Pick the first valid requester after the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
`ifdef SEQ_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        res_d     = res_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found && !Reset) begin
                    req_ready = NREQ'(1) << win;
                    sh_d      = req_data[int'(win)*FRAME_LEN +: FRAME_LEN];
                    id_d      = win;
                    state_d   = CLR;
`ifdef SEQ_ARB_PRIO0_EN
                    if (!req_valid[0]) begin
                        ptr_d = win;
                    end
`else
                    ptr_d = win;
`endif
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                res_d = (res_q >> 1)
                      | (FRAME_LEN'(core_dout) << (FRAME_LEN - 1));
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(FRAME_LEN - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
        end
    end

    assign core_rst  = Reset | (state_q == CLR);
    assign core_din  = (state_q == SHIFT) & sh_q[0];
    assign res_valid = (state_q == RESP);
    assign res_id    = id_q;
    assign res_data  = res_q;

endmodule

// File: tb/tb_seq_stream_arbiter.sv
// tb_seq_stream_arbiter: scoreboard bench with a Mealy core model.
// Build with SEQ_ARB_PRIO0_EN to exercise requester-0 priority.
module tb_seq_stream_arbiter;

    localparam int NREQ = 4;
    localparam int FL   = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 Reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FL-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 core_rst;
    logic                 core_din;
    logic                 core_dout;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [FL-1:0]        res_data;
    logic                 res_ready;

    seq_stream_arbiter #(
        .NREQ(NREQ), .FRAME_LEN(FL), .IDW(IDW)
    ) dut (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready),
        .core_rst(core_rst), .core_din(core_din),
        .core_dout(core_dout),
        .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    // External shared core: 4-state Mealy transducer.
    logic [1:0] cs;
    always @(posedge clk or posedge core_rst) begin
        if (core_rst) cs <= 2'd0;
        else begin
            case (cs)
                2'd0: cs <= core_din ? 2'd1 : 2'd0;
                2'd1: cs <= core_din ? 2'd3 : 2'd2;
                2'd2: cs <= core_din ? 2'd3 : 2'd0;
                default: cs <= core_din ? 2'd0 : 2'd3;
            endcase
        end
    end
    always_comb begin
        case (cs)
            2'd0: core_dout = core_din;
            2'd1: core_dout = ~core_din;
            2'd2: core_dout = core_din;
            default: core_dout = core_din;
        endcase
    end

    // Reference: transition/output tables applied bit by bit.
    int NXT [4][2] = '{'{0, 1}, '{2, 3}, '{0, 3}, '{3, 0}};
    int OUTB[4][2] = '{'{0, 1}, '{1, 0}, '{0, 1}, '{0, 1}};

    function automatic logic [FL-1:0] xform(logic [FL-1:0] w);
        logic [FL-1:0] r;
        int s;
        int b;
        s = 0;
        r = '0;
        for (int i = 0; i < FL; i++) begin
            b    = int'(w[i]);
            r[i] = OUTB[s][b][0];
            s    = NXT[s][b];
        end
        return r;
    endfunction

    function automatic int pick(logic [NREQ-1:0] rv, int p);
`ifdef SEQ_ARB_PRIO0_EN
        if (rv[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++)
            if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    typedef struct {
        int            id;
        logic [FL-1:0] d;
        int            gc;
    } exp_t;

    exp_t mq[$];
    int   gq[$];
    int   mptr      = NREQ - 1;
    bit   midle     = 1'b1;
    int   last_g    = -1;
    bit   chk_space = 1'b0;

    // Arbiter model: predicts each grant and queues its result.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int w;
        exp_t e;
        if (Reset) begin
            mq.delete();
            midle  = 1'b1;
            mptr   = NREQ - 1;
            last_g = -1;
        end else begin
            er = '0;
            w  = -1;
            if (midle) w = pick(req_valid, mptr);
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (w >= 0) begin
                e.id = w;
                e.d  = xform(req_data[w*FL +: FL]);
                e.gc = cyc;
                mq.push_back(e);
                gq.push_back(w);
                if (chk_space && last_g >= 0)
                    chk("spacing", 32'(cyc - last_g), 32'(FL + 3));
                last_g = cyc;
                midle  = 1'b0;
`ifdef SEQ_ARB_PRIO0_EN
                if (!req_valid[0]) mptr = w;
`else
                mptr = w;
`endif
            end
            if (res_valid && res_ready) midle = 1'b1;
        end
    end

    bit seen = 1'b0;

    // Result monitor: compares presented results to the queue head.
    always @(negedge clk) begin
        if (Reset) begin
            seen = 1'b0;
        end else if (res_valid) begin
            if (mq.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - mq[0].gc), 32'(FL + 2));
                    seen = 1'b1;
                end
                chk("res_id", 32'(res_id), 32'(mq[0].id));
                chk("res_data", 32'(res_data), 32'(mq[0].d));
                if (res_ready) begin
                    void'(mq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_grant(string n);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready != '0) return;
        end
        chk({n, "_grant_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_res(string n, int id, logic [FL-1:0] d);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (res_valid) begin
                chk({n, "_id"}, 32'(res_id), 32'(id));
                chk({n, "_data"}, 32'(res_data), 32'(d));
                return;
            end
        end
        chk({n, "_res_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
    endtask

    task automatic wait_gq(int n);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (gq.size() >= n) return;
        end
        chk("order_timeout", 32'(gq.size()), 32'(n));
    endtask

    logic [NREQ-1:0] nv;
    int ord3[5] = '{0, 1, 2, 3, 0};
    int ord6[3] = '{1, 2, 3};
    logic [3:0] s1bits;

    initial begin
        Reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_core_din", 32'(core_din), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        @(posedge clk); #1 Reset = 1'b0;

        // Scenario 1: single frame, cycle by cycle.
        req_data[0 +: FL] = 4'b0101;
        req_valid         = 4'b0001;
        @(negedge clk);
        chk("s1_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("s1_clr_rst", 32'(core_rst), 32'd1);
        chk("s1_clr_din", 32'(core_din), 32'd0);
        chk("s1_clr_ready", 32'(req_ready), 32'd0);
        s1bits = 4'b0101;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk($sformatf("s1_din%0d", i), 32'(core_din),
                32'(s1bits[i]));
            chk($sformatf("s1_rst%0d", i), 32'(core_rst), 32'd0);
        end
        @(negedge clk);
        chk("s1_valid", 32'(res_valid), 32'd1);
        chk("s1_id", 32'(res_id), 32'd0);
        chk("s1_data", 32'(res_data), 32'b0111);
        repeat (2) @(posedge clk);

        // Scenario 2: other requester, all-ones and all-zeros data.
        #1;
        req_data[2*FL +: FL] = 4'b1111;
        req_valid            = 4'b0100;
        wait_grant("s2a");
        @(posedge clk); #1 req_valid = '0;
        wait_res("s2a", 2, 4'b1101);
        @(posedge clk); #1;
        req_data[2*FL +: FL] = 4'b0000;
        req_valid            = 4'b0100;
        wait_grant("s2b");
        @(posedge clk); #1 req_valid = '0;
        wait_res("s2b", 2, 4'b0000);

        // Scenario 3/6: all requesters held, check grant order.
        pulse_reset();
        gq.delete();
        chk_space = 1'b1;
        req_data  = NREQ*FL'($urandom);
        req_valid = 4'b1111;
        wait_gq(5);
        #1;
`ifdef SEQ_ARB_PRIO0_EN
        for (int i = 0; i < 5; i++)
            chk($sformatf("prio_order%0d", i), 32'(gq[i]), 32'd0);
        gq.delete();
        req_valid = 4'b1110;
        wait_gq(3);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("drop0_order%0d", i), 32'(gq[i]),
                32'(ord6[i]));
`else
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), 32'(gq[i]),
                32'(ord3[i]));
`endif
        req_valid = '0;
        chk_space = 1'b0;
        repeat (12) @(posedge clk);

        // Scenario 4: hold the result with res_ready low.
        #1;
        res_ready            = 1'b0;
        req_data[1*FL +: FL] = 4'($urandom);
        req_data[3*FL +: FL] = 4'($urandom);
        req_valid            = 4'b0010;
        wait_grant("s4");
        @(posedge clk); #1 req_valid = 4'b1000;
        for (int i = 0; i < 64 && !res_valid; i++) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_grant("s4_next");
        @(posedge clk); #1 req_valid = '0;
        chk("s4_next_id", 32'(gq[gq.size()-1]), 32'd3);
        repeat (10) @(posedge clk);

        // Scenario 5: reset during the second shift cycle.
        #1;
        req_data[0 +: FL] = 4'b0101;
        req_valid         = 4'b0001;
        wait_grant("s5");
        @(posedge clk); #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;
        #1;
        chk("s5_res_valid", 32'(res_valid), 32'd0);
        chk("s5_core_rst", 32'(core_rst), 32'd1);
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        req_valid = 4'b0001;
        wait_grant("s5_after");
        @(posedge clk); #1 req_valid = '0;
        wait_res("s5_after", 0, 4'b0111);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            nv = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i]) req_data[i*FL +: FL] = FL'($urandom);
            req_valid = nv;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (20) @(posedge clk);
        chk("drain", 32'(mq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_stream_arbiter.md
Name: seq_stream_arbiter

Overview:
- Shares one external serial Mealy transducer core (ports Reset/clk/Din/Dout) among NREQ requesters.
- Grants one requester at a time, round-robin.
- Per granted frame: clears the core, shifts the requester's FRAME_LEN-bit word into the core LSB-first, and captures the core output bit-per-cycle into a result word.
- Returns the result word with the requester ID over a valid/ready channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_LEN, 8, bits per frame (1..32).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester frame request.
- req_data  input  NREQ*FRAME_LEN  flattened frame words; requester i occupies bits [i*FRAME_LEN +: FRAME_LEN].
- req_ready  output  NREQ  one-hot accept strobe.
- core_rst  output  1  reset to shared core.
- core_din  output  1  serial bit to core.
- core_dout  input  1  core Mealy output; combinational in core_din.
- res_valid  output  1  result available.
- res_id  output  IDW  requester index of the result.
- res_data  output  FRAME_LEN  captured core output, LSB = first bit.
- res_ready  input  1  result consumer accept.

Behaviour:
- Reset (async) values: state IDLE; req_ready=0; core_din=0; res_valid=0; res_id=0; res_data=0; rr pointer = NREQ-1 (first grant search starts at 0); bit counter=0.
- core_rst = Reset OR (state==CLR); combinational.
- States:
  - IDLE: req_ready is combinational, one-hot on the winner, only in IDLE and only if any req_valid. Winner = first set req_valid scanning (ptr+1)..(ptr+NREQ) mod NREQ. On accept (posedge with winner): latch req_data slice into shift reg, latch winner into res_id and ptr, go CLR.
  - CLR: one cycle; core_rst=1; core_din=0; counter=0; go SHIFT.
  - SHIFT: FRAME_LEN cycles. core_din = shift_reg[0]. Each posedge: result shift reg takes core_dout in at MSB and shifts right (after FRAME_LEN bits, first bit lands at LSB); data shift reg shifts right; counter++. At counter==FRAME_LEN-1, go RESP.
  - RESP: res_valid=1; res_data/res_id stable. On res_valid&&res_ready, go IDLE and drop res_valid next cycle.
- Latency: accept at edge T → res_valid high in cycle after edge T+1+FRAME_LEN, i.e. FRAME_LEN+2 cycles after accept.
- Back-to-back: with res_ready tied 1, RESP lasts 1 cycle; the next grant occurs in IDLE the cycle after. Throughput is one frame per FRAME_LEN+3 cycles.
- Requester must hold req_valid/req_data until its req_ready. Deasserting before grant is legal; it is simply skipped.
- Non-granted requesters see req_ready=0 outside IDLE. Requests arriving during SHIFT/RESP wait.
- Fairness: a requester continuously asserting is granted at least once every NREQ frames.
- Reset mid-SHIFT/RESP: immediate return to IDLE; partial result discarded; res_valid=0; core_rst asserted via Reset.
- FRAME_LEN=1: SHIFT lasts exactly one cycle.
- core_din outside SHIFT = 0.

Optional Feature:
- Macro SEQ_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. If req_valid[0] in IDLE, it wins regardless of ptr. Among others, round-robin is unchanged, and ptr is not updated on a requester-0 grant.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
Bench core model is the 4-state Mealy transducer below (state, Din → next state, Dout); state resets to S0 on core_rst:
- S0: Din=1 → S1, out 1; Din=0 → S0, out 0.
- S1: Din=1 → S3, out 0; Din=0 → S2, out 1.
- S2: Din=1 → S3, out 1; Din=0 → S0, out 0.
- S3: Din=1 → S0, out 1; Din=0 → S3, out 0.

Scenarios (FRAME_LEN=4, NREQ=4):
1. Reset, then req_valid=4'b0001 with data0=4'b0101 → req_ready=4'b0001 for one cycle. core_rst pulses one cycle. core_din sequence 1,0,1,0. res_valid after 6 cycles with res_id=0, res_data=4'b0111.
2. data2=4'b1111, only req 2 → res_id=2, res_data=4'b1101. data 4'b0000 → res_data=4'b0000.
3. req_valid=4'b1111 held, res_ready=1 → grant order 0,1,2,3,0. Grant spacing 7 cycles.
4. res_ready=0 for 10 cycles in RESP → res_valid and res_data stable, no req_ready pulses. Releasing res_ready → next grant follows.
5. Assert Reset during 2nd SHIFT cycle → res_valid=0, core_rst=1 immediately. After release, IDLE; the next frame produces the correct result (4'b0111 for 4'b0101).
6. With SEQ_ARB_PRIO0_EN, req_valid=4'b1111 held → requester 0 granted every frame. Drop req 0 → order 1,2,3.
